// File: rtl/inst_encoder.sv
// inst_encoder: turns RV32I field descriptors into 32-bit instruction words.
// One output register, valid/ready on both sides, auto-incrementing byte address.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// valid may not depend on ready; once out_valid is high, out_inst/out_addr/out_err
// stay stable until the consumer takes the word. in_ready = !out_valid | out_ready.
module inst_encoder #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;

  logic [31:0]       enc_inst;
  logic              enc_err;
  logic              imm12_ok, shamt_ok, imm13_ok, imm21_ok, is_shift;
  logic              accept;
  logic [ADDR_W-1:0] base_aligned, word_addr;

  // Immediate range classification: a value fits an N-bit signed field when all
  // bits above the field's sign bit replicate it.
  always_comb begin
    imm12_ok = (in_imm[31:11] == {21{in_imm[11]}});
    shamt_ok = (in_imm[31:5] == 27'd0);
    imm13_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
    imm21_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
    is_shift = (in_opcode == OP_IMM) && (in_funct3[1:0] == 2'b01);
  end

  // Encode the descriptor by format; unencodable descriptors become a NOP.
  always_comb begin
    enc_inst = NOP;
    enc_err  = 1'b0;
    unique case (in_opcode)
      OP_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        if (is_shift) begin
          enc_err  = !shamt_ok;
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        end else begin
          enc_err  = !imm12_ok;
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        end
      end
      OP_STORE: begin
        enc_err  = !imm12_ok;
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      end
      OP_BRANCH: begin
        enc_err  = !imm13_ok;
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      end
      OP_LUI, OP_AUIPC: begin
        enc_err  = (in_imm[11:0] != 12'd0);
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
      end
      OP_JAL: begin
        enc_err  = !imm21_ok;
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_inst = NOP;
  end

  // Handshake, address counter and output register next-state.
  always_comb begin
    in_ready     = !out_valid_q || out_ready;
    accept       = in_valid && in_ready;
    base_aligned = {base_addr[ADDR_W-1:2], 2'b00};
    word_addr    = base_load ? base_aligned : cnt_q;

    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    err_count_d = err_count_q;
    cnt_d       = cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_addr_d  = word_addr;
      out_err_d   = enc_err;
      cnt_d       = word_addr + ADDR_W'(4);
      if (enc_err && (err_count_q != {CNT_W{1'b1}})) err_count_d = err_count_q + CNT_W'(1);
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (base_load) cnt_d = base_aligned;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed RV32I vectors plus randomized traffic checked
// against an arithmetic reference encoder and a transaction queue.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        base_load = 1'b0;
  logic [9:0]  base_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // expected queue entries: {err, addr[9:0], inst[31:0]}
  logic [42:0] exp_q[$];
  int          m_cnt  = 0;
  int          m_errc = 0;
  logic        obs_ready, exp_ready;

  inst_encoder #(.ADDR_W(10), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .base_load(base_load), .base_addr(base_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count)
  );

  // clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm,
                                     output logic [31:0] inst, output logic err);
    longint s;
    logic [31:0] regs;
    s    = longint'($signed(imm));
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    err  = 1'b0;
    inst = 32'd0;
    case (op)
      7'h33: inst = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'(op);
      7'h13, 7'h03, 7'h67, 7'h73: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          err  = !(s >= 0 && s <= 31);
          inst = (32'(f7) << 25) | (bits(imm, 4, 0) << 20) | regs | (32'(rd) << 7) | 32'(op);
        end else begin
          err  = !(s >= -2048 && s <= 2047);
          inst = (bits(imm, 11, 0) << 20) | regs | (32'(rd) << 7) | 32'(op);
        end
      end
      7'h23: begin
        err  = !(s >= -2048 && s <= 2047);
        inst = (bits(imm, 11, 5) << 25) | (32'(rs2) << 20) | regs |
               (bits(imm, 4, 0) << 7) | 32'(op);
      end
      7'h63: begin
        err  = !(s >= -4096 && s <= 4094) || (imm[0] == 1'b1);
        inst = (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | (32'(rs2) << 20) |
               regs | (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7) | 32'(op);
      end
      7'h37, 7'h17: begin
        err  = (bits(imm, 11, 0) != 32'd0);
        inst = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      end
      7'h6F: begin
        err  = !(s >= -1048576 && s <= 1048574) || (imm[0] == 1'b1);
        inst = (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20) |
               (bits(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
      end
      default: err = 1'b1;
    endcase
    if (err) inst = 32'h0000_0013;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_desc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    logic [31:0] ri;
    logic        re;
    int          a;
    #1;
    obs_ready = in_ready;
    exp_ready = (exp_q.size() == 0) || out_ready;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt  = 0;
      m_errc = 0;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_ready) begin
        ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, ri, re);
        a = base_load ? (int'(base_addr) & 32'h3FC) : m_cnt;
        exp_q.push_back({re, 10'(a), ri});
        m_cnt = (a + 4) % 1024;
        if (re && m_errc < 255) m_errc++;
      end else if (base_load) begin
        m_cnt = int'(base_addr) & 32'h3FC;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_inst !== 32'd0) begin n_bad++; $display("FAIL reset_inst got %h want 0", out_inst); end
    n_cmp++; if (out_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %h want 0", out_addr); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b want 0", out_err); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_addi();
    set_desc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_inst !== 32'hFFF0_0093) begin n_bad++; $display("FAIL addi_inst got %h want FFF00093", out_inst); end
    n_cmp++; if (out_addr !== 10'd0) begin n_bad++; $display("FAIL addi_addr got %h want 0", out_addr); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL addi_err got %0b want 0", out_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_desc(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
    in_valid = 1'b1; tick();
    n_cmp++; if (out_inst !== 32'h0021_A423 || out_addr !== 10'h000)
      begin n_bad++; $display("FAIL sw_word got %h@%h want 0021A423@000", out_inst, out_addr); end
    set_desc(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    tick(); in_valid = 1'b0;
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", obs_ready); end
    n_cmp++; if (out_inst !== 32'hFE00_0EE3 || out_addr !== 10'h004 || out_valid !== 1'b1)
      begin n_bad++; $display("FAIL beq_word got %h@%h v%0b want FE000EE3@004 v1", out_inst, out_addr, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_u_j();
    logic [31:0] want [3];
    logic        werr [3];
    logic [31:0] imms [3];
    logic [6:0]  ops  [3];
    logic [4:0]  rds  [3];
    want = '{32'h0010_00EF, 32'h1234_52B7, 32'h0000_0013};
    werr = '{1'b0, 1'b0, 1'b1};
    imms = '{32'd2048, 32'h1234_5000, 32'h1234_5001};
    ops  = '{7'h6F, 7'h37, 7'h37};
    rds  = '{5'd1, 5'd5, 5'd5};
    for (int i = 0; i < 3; i++) begin
      set_desc(ops[i], rds[i], 5'd0, 5'd0, 3'd0, 7'd0, imms[i]);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      n_cmp++; if (out_inst !== want[i] || out_err !== werr[i] || exp_q.size() == 0 ||
                   out_addr !== exp_q[0][41:32])
        begin n_bad++; $display("FAIL uj_%0d got %h err%0b @%h want %h err%0b", i, out_inst, out_err, out_addr, want[i], werr[i]); end
    end
    tick();
  endtask

  task automatic test_errors();
    do_reset();
    set_desc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    in_valid = 1'b1; tick();
    n_cmp++; if (out_inst !== 32'h13 || out_err !== 1'b1 || out_addr !== 10'h000)
      begin n_bad++; $display("FAIL addi2048 got %h err%0b @%h want 00000013 err1 @000", out_inst, out_err, out_addr); end
    set_desc(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick(); in_valid = 1'b0;
    n_cmp++; if (out_inst !== 32'h13 || out_err !== 1'b1 || out_addr !== 10'h004)
      begin n_bad++; $display("FAIL beq3 got %h err%0b @%h want 00000013 err1 @004", out_inst, out_err, out_addr); end
    n_cmp++; if (err_count !== 8'd2) begin n_bad++; $display("FAIL errcnt2 got %0d want 2", err_count); end
    tick();
  endtask

  task automatic test_stall();
    logic [42:0] held;
    set_desc(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1; out_ready = 1'b1; tick();
    held = {out_err, out_addr, out_inst};
    n_cmp++; if (out_inst !== 32'h0050_0113) begin n_bad++; $display("FAIL stall_a got %h want 00500113", out_inst); end
    set_desc(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready_%0d got %0b want 0", i, obs_ready); end
      n_cmp++; if (out_valid !== 1'b1 || {out_err, out_addr, out_inst} !== held)
        begin n_bad++; $display("FAIL stall_hold_%0d got %h want %h", i, {out_err, out_addr, out_inst}, held); end
    end
    out_ready = 1'b1; tick(); in_valid = 1'b0;
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL resume_ready got %0b want 1", obs_ready); end
    n_cmp++; if (out_inst !== 32'h0070_0193 || out_addr !== held[41:32] + 10'd4)
      begin n_bad++; $display("FAIL resume_b got %h@%h want 00700193@%h", out_inst, out_addr, held[41:32] + 10'd4); end
    tick();
  endtask

  task automatic test_base_load();
    set_desc(7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid = 1'b1; out_ready = 1'b1; base_load = 1'b1; base_addr = 10'h101; tick();
    base_load = 1'b0;
    n_cmp++; if (out_addr !== 10'h100) begin n_bad++; $display("FAIL base_first got %h want 100", out_addr); end
    tick();
    n_cmp++; if (out_addr !== 10'h104) begin n_bad++; $display("FAIL base_next got %h want 104", out_addr); end
    out_ready = 1'b0; base_load = 1'b1; base_addr = 10'h3FE; tick();
    base_load = 1'b0;
    n_cmp++; if (out_addr !== 10'h104 || out_valid !== 1'b1)
      begin n_bad++; $display("FAIL base_held got %h v%0b want 104 v1", out_addr, out_valid); end
    out_ready = 1'b1; tick();
    n_cmp++; if (out_addr !== 10'h3FC) begin n_bad++; $display("FAIL wrap_pre got %h want 3FC", out_addr); end
    tick(); in_valid = 1'b0;
    n_cmp++; if (out_addr !== 10'h000) begin n_bad++; $display("FAIL wrap_zero got %h want 000", out_addr); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_desc(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL errcnt_sat got %0d want 255", err_count); end
    n_cmp++; if (out_inst !== 32'h13 || out_err !== 1'b1)
      begin n_bad++; $display("FAIL badop got %h err%0b want 00000013 err1", out_inst, out_err); end
    tick();
  endtask

  task automatic test_reset_midstream();
    set_desc(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    in_valid = 1'b1; out_ready = 1'b0; tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending got %0b want 1", out_valid); end
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || err_count !== 8'd0)
      begin n_bad++; $display("FAIL mid_drop got v%0b cnt%0d want v0 cnt0", out_valid, err_count); end
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    int         edges [15];
    ops   = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0F};
    edges = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 31, 32, 0, -1,
              1048574, 1048576, -1048576};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      base_load = ($urandom_range(0, 19) == 0);
      base_addr = 10'($urandom);
      set_desc(ops[$urandom_range(0, 11)], 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), 32'($urandom));
      case ($urandom_range(0, 3))
        0: in_imm = 32'($signed($urandom_range(0, 80)) - 40);
        1: in_imm = 32'(edges[$urandom_range(0, 14)]);
        2: in_imm = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h00000, 12'($urandom)} & ~32'h1;
        default: in_imm = in_imm & 32'hFFFF_F000;
      endcase
      tick();
      n_cmp++; if (obs_ready !== exp_ready)
        begin n_bad++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, obs_ready, exp_ready); end
      n_cmp++; if (out_valid !== (exp_q.size() != 0))
        begin n_bad++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        n_cmp++; if ({out_err, out_addr, out_inst} !== exp_q[0])
          begin n_bad++; $display("FAIL rnd_word c%0d got %h want %h", c, {out_err, out_addr, out_inst}, exp_q[0]); end
      end
      n_cmp++; if (err_count !== 8'(m_errc))
        begin n_bad++; $display("FAIL rnd_errcnt c%0d got %0d want %0d", c, err_count, m_errc); end
    end
    in_valid = 1'b0; base_load = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #2;
    test_reset();
    test_addi();
    test_back_to_back();
    test_u_j();
    test_errors();
    test_stall();
    test_base_load();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
